// File: rtl/riscv_mem_pkg.sv
// Shared types and widths for the unified memory port of the RISC-V core.
package riscv_mem_pkg;
    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;
endpackage

// File: rtl/arb_timeout_counter.sv
// Counts memory wait cycles of the current transaction and flags when the
// abort limit is reached; a zero limit disables expiry entirely.
module arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Holding at LIMIT keeps the counter from wrapping if the owner stalls.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr_i) begin
            wait_cnt_d = '0;
        end else if (en_i && (wait_cnt_q != LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (wait_cnt_q == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto the single memory port,
// holds ownership until completion or timeout and routes the response back.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_PRIORITY = 1,
    parameter int STARVE_LIMIT  = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [BE_W-1:0] ls_be,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_ack,
    output logic [XLEN-1:0] rdata,
    output logic            err,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_sel,
    output logic            busy
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_e      state_q, state_d;
    owner_e          sel_q, sel_d;
    logic [3:0]      starve_q, starve_d;
    logic            we_q, we_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic in_busy, expired, done, abort, ack, grant_ls;

    assign in_busy = (state_q == ARB_BUSY);
    assign done    = in_busy & mem_ready;
    assign abort   = in_busy & expired & ~mem_ready;
    assign ack     = done | abort;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (~in_busy),
        .en_i      (in_busy & ~mem_ready),
        .expired_o (expired)
    );

    // sel_q doubles as the last owner for round-robin: both reset to IF.
    always_comb begin
        if (DATA_PRIORITY != 0) begin
            grant_ls = ls_req & ~(if_req & (starve_q == STARVE_MAX));
        end else begin
            grant_ls = ls_req & (~if_req | (sel_q == OWN_IF));
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        starve_d = starve_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_req | ls_req) begin
                    state_d = ARB_BUSY;
                    if (grant_ls) begin
                        sel_d   = OWN_LS;
                        we_d    = ls_we;
                        be_d    = ls_be;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        if (if_req && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        sel_d    = OWN_IF;
                        we_d     = 1'b0;
                        be_d     = '1;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        starve_d = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            sel_q    <= OWN_IF;
            starve_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_valid = in_busy;
    assign busy      = in_busy;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_sel   = sel_q;
    assign if_ack    = ack & (sel_q == OWN_IF);
    assign ls_ack    = ack & (sel_q == OWN_LS);
    assign err       = abort;
    assign rdata     = done ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority instance (TIMEOUT=5) plus a
// round-robin instance sharing the requester inputs, each with its own queue.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    typedef struct packed {
        logic        own;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF ^ 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [3:0]  ls_be = '0;

    logic        if_ack, ls_ack, err, mem_valid, mem_we, mem_sel, busy;
    logic [3:0]  mem_be;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        rr_if_ack, rr_ls_ack, rr_err, rr_mem_valid, rr_mem_we, rr_mem_sel, rr_busy;
    logic [3:0]  rr_mem_be;
    logic [31:0] rr_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;

    // Memory model: read data is a keyed function of the presented address.
    assign mem_rdata    = mem_addr ^ KEY;
    assign rr_mem_rdata = rr_mem_addr ^ KEY;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_PRIORITY(1), .STARVE_LIMIT(4), .TIMEOUT(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack),
        .rdata(rdata), .err(err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_sel(mem_sel), .busy(busy)
    );

    mem_port_arbiter #(.DATA_PRIORITY(0), .STARVE_LIMIT(4), .TIMEOUT(5)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(rr_if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(rr_ls_ack),
        .rdata(rr_rdata), .err(rr_err),
        .mem_valid(rr_mem_valid), .mem_we(rr_mem_we), .mem_be(rr_mem_be), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_ready(mem_ready), .mem_rdata(rr_mem_rdata),
        .mem_sel(rr_mem_sel), .busy(rr_busy)
    );

    int   total = 0;
    int   bad = 0;
    logic rr_en = 1'b0;
    exp_t exp_q[$];
    exp_t rr_q[$];
    exp_t mon_e, rr_e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic own, input logic [31:0] addr, input logic we,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] rd, input logic e);
        exp_t x;
        x.own = own; x.addr = addr; x.we = we; x.be = be;
        x.wdata = wdata; x.rdata = rd; x.err = e;
        return x;
    endfunction

    // Scoreboard for the fixed-priority instance.
    always @(negedge clk) begin
        if (rst_n && (if_ack || ls_ack)) begin
            if (exp_q.size() == 0) begin
                chk("unexp_ack", {30'd0, if_ack, ls_ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_excl", 32'(if_ack & ls_ack), 32'd0);
                chk("owner", 32'(ls_ack), 32'(mon_e.own));
                chk("sel", 32'(mem_sel), 32'(mon_e.own));
                chk("addr", mem_addr, mon_e.addr);
                chk("we", 32'(mem_we), 32'(mon_e.we));
                chk("be", 32'(mem_be), 32'(mon_e.be));
                if (mon_e.we) chk("wdata", mem_wdata, mon_e.wdata);
                chk("rdata", rdata, mon_e.rdata);
                chk("err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    // Scoreboard for the round-robin instance, active only in its sections.
    always @(negedge clk) begin
        if (rst_n && rr_en && (rr_if_ack || rr_ls_ack)) begin
            if (rr_q.size() == 0) begin
                chk("rr_unexp_ack", {30'd0, rr_if_ack, rr_ls_ack}, 32'd0);
            end else begin
                rr_e = rr_q.pop_front();
                chk("rr_owner", 32'(rr_ls_ack), 32'(rr_e.own));
                chk("rr_sel", 32'(rr_mem_sel), 32'(rr_e.own));
                chk("rr_addr", rr_mem_addr, rr_e.addr);
                chk("rr_rdata", rr_rdata, rr_e.rdata);
            end
        end
    end

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!(if_ack || ls_ack) && cycles < 40);
        if (!(if_ack || ls_ack)) chk("ack_wait", 32'(if_ack | ls_ack), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        int lat;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a; mem_ready = 1'b1;
        exp_q.push_back(mk(OWN_IF, a, 1'b0, 4'hF, 32'd0, a ^ KEY, 1'b0));
        if (rr_en) rr_q.push_back(mk(OWN_IF, a, 1'b0, 4'hF, 32'd0, a ^ KEY, 1'b0));
        wait_ack(lat);
        chk("fetch_lat", 32'(lat), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be_we_sel", {28'd0, mem_be}, 32'd0);
        chk("rst_we_sel", {30'd0, mem_we, mem_sel}, 32'd0);
        chk("rst_acks_err", {29'd0, if_ack, ls_ack, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single fetch with zero-wait memory.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0040; mem_ready = 1'b1;
        exp_q.push_back(mk(OWN_IF, 32'h40, 1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b0));
        wait_ack(lat);
        chk("fetch1_lat", 32'(lat), 32'd1);
        chk("fetch1_valid", 32'(mem_valid), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch1_idle", 32'(mem_valid), 32'd0);

        // Store with three wait states.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h100; ls_wdata = 32'h1234;
        exp_q.push_back(mk(OWN_LS, 32'h100, 1'b1, 4'b0011, 32'h1234, 32'h100 ^ KEY, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            if (k == 4) begin #1; mem_ready = 1'b1; end
            @(negedge clk);
            chk("st_valid", 32'(mem_valid), 32'd1);
            chk("st_addr", mem_addr, 32'h100);
            chk("st_wdata", mem_wdata, 32'h1234);
            chk("st_be_we", {27'd0, mem_we, mem_be}, {27'd0, 1'b1, 4'b0011});
            chk("st_ack", 32'(ls_ack), 32'(k == 4));
        end
        @(posedge clk); #1;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'hF;
        @(negedge clk);
        chk("st_idle", 32'(mem_valid), 32'd0);

        // Contention: fixed priority with starvation guard vs round-robin.
        do_reset();
        rr_en = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        if_addr = 32'h200; ls_addr = 32'h300; ls_we = 1'b0; ls_be = 4'hF; ls_wdata = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) exp_q.push_back(mk(OWN_IF, 32'h200, 1'b0, 4'hF, 32'd0, 32'h200 ^ KEY, 1'b0));
            else exp_q.push_back(mk(OWN_LS, 32'h300, 1'b0, 4'hF, 32'd0, 32'h300 ^ KEY, 1'b0));
            if ((i % 2) == 0) rr_q.push_back(mk(OWN_LS, 32'h300, 1'b0, 4'hF, 32'd0, 32'h300 ^ KEY, 1'b0));
            else rr_q.push_back(mk(OWN_IF, 32'h200, 1'b0, 4'hF, 32'd0, 32'h200 ^ KEY, 1'b0));
        end
        if_req = 1'b1; ls_req = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (if_ack || ls_ack) n++;
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        chk("contend_drain", 32'(exp_q.size()), 32'd0);
        chk("rr_contend_drain", 32'(rr_q.size()), 32'd0);

        // Lone fetches always win, in either arbitration mode.
        do_fetch(32'h0000_0800);
        do_fetch(32'h0000_0804);
        do_fetch(32'h0000_0808);
        chk("rr_lone_drain", 32'(rr_q.size()), 32'd0);
        rr_en = 1'b0;

        // Timeout abort with memory stuck not-ready.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h400;
        exp_q.push_back(mk(OWN_LS, 32'h400, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1));
        wait_ack(lat);
        chk("to_lat", 32'(lat), 32'd6);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        chk("to_idle_valid", 32'(mem_valid), 32'd0);
        chk("to_idle_busy", 32'(busy), 32'd0);

        // Ready in the expiry cycle completes normally.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_addr = 32'h500;
        exp_q.push_back(mk(OWN_LS, 32'h500, 1'b0, 4'hF, 32'd0, 32'h500 ^ KEY, 1'b0));
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            if (k == 6) begin #1; mem_ready = 1'b1; end
            @(negedge clk);
            chk("to2_ack", 32'(ls_ack), 32'(k == 6));
        end
        @(posedge clk); #1;
        ls_req = 1'b0;

        // Reset in the middle of a waiting fetch.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if_req = 1'b1; if_addr = 32'h600;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(mem_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
        if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_fetch(32'h0000_0700);

        repeat (2) @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
